// File: rtl/add_disp_pkg.sv
// Shared constants for the adder display controller:
// segment codes, FSM states, digit slots and BCD helper.
package add_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_Y    = 2'd2;
  localparam logic [1:0] DIG_X    = 2'd3;

  localparam int BCD_ITERS = 5;

  // One shift-add-3 iteration on {tens, ones, bin[4:0]}.
  function automatic logic [12:0] bcd_step(input logic [12:0] r);
    logic [3:0] t;
    logic [3:0] o;
    t = r[12:9];
    o = r[8:5];
    if (o >= 4'd5) o = o + 4'd3;
    if (t >= 4'd5) t = t + 4'd3;
    return {t[2:0], o, r[4:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational; bit0 = a ... bit6 = g.
module seg7_hex_dec
  import add_disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Nibble lookup
  always_comb begin
    seg_o = SEG_BLANK;
    unique case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/add_disp_scan_ctrl.sv
// Adder sequencer: capture, shift-add-3 BCD, atomic commit,
// and a free-running 4-digit multiplexed display scan.
module add_disp_scan_ctrl
  import add_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       LOAD,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       C_IN,
  output logic       BUSY,
  output logic       SUM_VALID,
  output logic [6:0] SEG,
  output logic [3:0] AN
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [2:0] ITER_LAST = 3'(BCD_ITERS - 1);

  state_e      state_q, state_d;
  logic [12:0] sh_q, sh_d;
  logic [2:0]  it_q, it_d;
  logic [3:0]  sx_q, sy_q;
  logic [3:0]  dx_q, dy_q, dt_q, do_q;
  logic        sv_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]  idx_q;
  logic        cap;
  logic        commit;
  logic [4:0]  sum5;
  logic [3:0]  nib;
  logic [6:0]  seg_raw;

  assign sum5 = {1'b0, X} + {1'b0, Y} + {4'b0, C_IN};

  // Next-state and conversion datapath
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    it_d    = it_q;
    cap     = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (LOAD) begin
          cap     = 1'b1;
          sh_d    = {8'd0, sum5};
          it_d    = 3'd0;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        sh_d = bcd_step(sh_q);
        it_d = it_q + 3'd1;
        if (it_q == ITER_LAST) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, shifter and operand shadow registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      it_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      it_q    <= it_d;
      if (cap) begin
        sx_q <= X;
        sy_q <= Y;
      end
    end
  end

  // Display registers, updated together on commit only
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dx_q <= '0;
      dy_q <= '0;
      dt_q <= '0;
      do_q <= '0;
      sv_q <= 1'b0;
    end else begin
      sv_q <= commit;
      if (commit) begin
        dx_q <= sx_q;
        dy_q <= sy_q;
        dt_q <= sh_q[12:9];
        do_q <= sh_q[8:5];
      end
    end
  end

  // Scan divider and digit index
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
      idx_q <= DIG_ONES;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Digit select
  always_comb begin
    nib = do_q;
    unique case (idx_q)
      DIG_ONES: nib = do_q;
      DIG_TENS: nib = dt_q;
      DIG_Y:    nib = dy_q;
      DIG_X:    nib = dx_q;
    endcase
  end

  seg7_hex_dec u_dec (
    .hex_i (nib),
    .seg_o (seg_raw)
  );

  assign BUSY      = (state_q != ST_IDLE);
  assign SUM_VALID = sv_q;
  assign AN        = ~(4'b0001 << idx_q);
  assign SEG       = (idx_q == DIG_TENS && dt_q == 4'd0)
                   ? SEG_BLANK : seg_raw;

endmodule

// File: tb/tb_add_disp_scan_ctrl.sv
// Randomized bench for add_disp_scan_ctrl against a
// decimal-arithmetic reference of the display contents.
module tb_add_disp_scan_ctrl;

  localparam int SD = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD = 1'b0;
  logic [3:0] X = '0;
  logic [3:0] Y = '0;
  logic       C_IN = 1'b0;
  logic       BUSY;
  logic       SUM_VALID;
  logic [6:0] SEG;
  logic [3:0] AN;

  add_disp_scan_ctrl #(.SCAN_DIV(SD)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .LOAD      (LOAD),
    .X         (X),
    .Y         (Y),
    .C_IN      (C_IN),
    .BUSY      (BUSY),
    .SUM_VALID (SUM_VALID),
    .SEG       (SEG),
    .AN        (AN)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n = 0;
  int mx = 0, my = 0, mt = 0, mo = 0;

  logic [6:0] segtab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  task automatic chk_disp();
    int idx;
    int val;
    logic [6:0] es;
    logic [3:0] ea;
    idx = (n / SD) % 4;
    case (idx)
      0: val = mo;
      1: val = mt;
      2: val = my;
      default: val = mx;
    endcase
    es = segtab[val];
    if (idx == 1 && mt == 0) es = 7'b1111111;
    ea = 4'b1111;
    ea[idx] = 1'b0;
    chk("an", 32'(AN), 32'(ea));
    chk("seg", 32'(SEG), 32'(es));
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    n++;
    chk_disp();
  endtask

  task automatic do_load(input int x, input int y, input int c,
                         input int extra_at);
    int s;
    X = 4'(x);
    Y = 4'(y);
    C_IN = 1'(c);
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    chk("busy_k", 32'(BUSY), 32'd1);
    chk("sv_k", 32'(SUM_VALID), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      if (j == extra_at) begin
        X = 4'd9;
        Y = 4'd9;
        C_IN = 1'b1;
        LOAD = 1'b1;
      end
      if (j == 6) begin
        s  = x + y + c;
        mx = x;
        my = y;
        mt = s / 10;
        mo = s % 10;
      end
      step();
      LOAD = 1'b0;
      if (j < 6) begin
        chk("busy_conv", 32'(BUSY), 32'd1);
        chk("sv_conv", 32'(SUM_VALID), 32'd0);
      end else begin
        chk("busy_done", 32'(BUSY), 32'd0);
        chk("sv_pulse", 32'(SUM_VALID), 32'd1);
      end
    end
    step();
    chk("sv_drop", 32'(SUM_VALID), 32'd0);
    chk("busy_idle", 32'(BUSY), 32'd0);
  endtask

  task automatic scan_all();
    for (int i = 0; i < 4 * SD; i++) step();
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    #1;
    chk_disp();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_sv", 32'(SUM_VALID), 32'd0);
    for (int i = 0; i < 5 * SD; i++) begin
      step();
      chk("idle_busy", 32'(BUSY), 32'd0);
    end

    do_load(2, 8, 0, 0);
    scan_all();
    do_load(15, 15, 1, 0);
    scan_all();
    do_load(3, 4, 0, 0);
    scan_all();
    do_load(5, 1, 1, 3);
    scan_all();
    do_load(7, 6, 0, 6);
    scan_all();

    for (int r = 0; r < 20; r++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) step();
      do_load($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 1), $urandom_range(0, 8));
    end
    scan_all();

    X = 4'd6;
    Y = 4'd7;
    C_IN = 1'b1;
    LOAD = 1'b1;
    step();
    LOAD = 1'b0;
    step();
    step();
    #2;
    RST = 1'b1;
    #1;
    mx = 0;
    my = 0;
    mt = 0;
    mo = 0;
    n = 0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_sv", 32'(SUM_VALID), 32'd0);
    chk_disp();
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4 * SD + 4; i++) begin
      step();
      chk("post_rst_sv", 32'(SUM_VALID), 32'd0);
      chk("post_rst_busy", 32'(BUSY), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
